// File: rtl/mac_seq_ctrl_if.sv
// Requester-side bundle for the sequential multiply-accumulate controller:
// request/operand inputs and handshake/result outputs.
interface mac_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+4
);
   logic                 start;
   logic                 accumulate;
   logic                 clear_acc;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [ACC_W-1:0]     acc;
   logic                 acc_ovf;

   modport master (
      output start, accumulate, clear_acc, a_in, b_in,
      input  busy, done, product, acc, acc_ovf
   );

   modport slave (
      input  start, accumulate, clear_acc, a_in, b_in,
      output busy, done, product, acc, acc_ovf
   );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequential unsigned multiply-accumulate controller: one WIDTH-bit ripple adder
// reused over WIDTH shift-and-add steps, then an optional add into a sticky-overflow accumulator.
module mac_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+4
) (
   input  logic           clk,
   input  logic           rst,
   mac_seq_ctrl_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Bit-serial carry chain: the single WIDTH-bit adder the multiplier iterates on.
   function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      logic [WIDTH:0] r;
      logic           c;
      c = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
      r[WIDTH] = c;
      return r;
   endfunction

   state_t               state_r;
   state_t               state_next_s;
   logic [WIDTH-1:0]     a_reg_r;
   logic [WIDTH-1:0]     b_reg_r;
   logic                 acc_flag_r;
   logic [WIDTH-1:0]     p_hi_r;
   logic [WIDTH-1:0]     p_lo_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [2*WIDTH-1:0]   product_r;
   logic [ACC_W-1:0]     acc_r;
   logic                 acc_ovf_r;
   logic [WIDTH-1:0]     addend_s;
   logic [WIDTH:0]       step_sum_s;
   logic [ACC_W:0]       acc_sum_s;
   logic                 cnt_last_s;

   assign cnt_last_s = (cnt_r == CNT_W'(WIDTH-1));

   // Datapath operands for the current shift-and-add step and the accumulator update.
   always_comb begin
      addend_s   = {WIDTH{1'b0}};
      step_sum_s = {(WIDTH+1){1'b0}};
      acc_sum_s  = {(ACC_W+1){1'b0}};
      if (b_reg_r[0]) begin
         addend_s = a_reg_r;
      end else begin
         addend_s = {WIDTH{1'b0}};
      end
      step_sum_s = ripple_add(p_hi_r, addend_s);
      // Carry lands in bit ACC_W so the sticky overflow sees it.
      acc_sum_s  = {1'b0, acc_r} + {{(ACC_W+1-2*WIDTH){1'b0}}, p_hi_r, p_lo_r};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               state_next_s = S_MUL;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_last_s) begin
               state_next_s = S_ACC;
            end else begin
               state_next_s = S_MUL;
            end
         end
         S_ACC:   state_next_s = S_DONE;
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Operand capture, shift-and-add iteration, product and accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg_r    <= {WIDTH{1'b0}};
         b_reg_r    <= {WIDTH{1'b0}};
         acc_flag_r <= 1'b0;
         p_hi_r     <= {WIDTH{1'b0}};
         p_lo_r     <= {WIDTH{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         product_r  <= {(2*WIDTH){1'b0}};
         acc_r      <= {ACC_W{1'b0}};
         acc_ovf_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.clear_acc) begin
                  acc_r     <= {ACC_W{1'b0}};
                  acc_ovf_r <= 1'b0;
               end
               if (bus.start) begin
                  a_reg_r    <= bus.a_in;
                  b_reg_r    <= bus.b_in;
                  acc_flag_r <= bus.accumulate;
                  p_hi_r     <= {WIDTH{1'b0}};
                  p_lo_r     <= {WIDTH{1'b0}};
                  cnt_r      <= {CNT_W{1'b0}};
               end
            end
            S_MUL: begin
               p_hi_r  <= step_sum_s[WIDTH:1];
               p_lo_r  <= {step_sum_s[0], p_lo_r[WIDTH-1:1]};
               b_reg_r <= {1'b0, b_reg_r[WIDTH-1:1]};
               cnt_r   <= cnt_r + CNT_W'(1);
            end
            S_ACC: begin
               product_r <= {p_hi_r, p_lo_r};
               if (acc_flag_r) begin
                  acc_r     <= acc_sum_s[ACC_W-1:0];
                  acc_ovf_r <= acc_ovf_r | acc_sum_s[ACC_W];
               end
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy    = (state_r != S_IDLE);
   assign bus.done    = (state_r == S_DONE);
   assign bus.product = product_r;
   assign bus.acc     = acc_r;
   assign bus.acc_ovf = acc_ovf_r;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl: latency, accumulation, overflow,
// busy-time request filtering, mid-operation reset and same-edge clear+start.
module tb_mac_seq_ctrl;
   localparam int WIDTH = 8;
   localparam int ACC_W = 20;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mac_seq_ctrl_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

   mac_seq_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issues one request and follows it to the return to idle; poke_k >= 0 raises
   // start and clear_acc (with 0xFF operands) for one cycle while busy.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic accf,
                        input logic clr, input int poke_k,
                        output int done_cnt, output int lat, output int busy_n);
      bus.start      = 1'b1;
      bus.a_in       = a;
      bus.b_in       = b;
      bus.accumulate = accf;
      bus.clear_acc  = clr;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.clear_acc  = 1'b0;
      bus.a_in       = ~a;
      bus.b_in       = ~b;
      bus.accumulate = ~accf;
      done_cnt = 0;
      lat      = -1;
      busy_n   = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            done_cnt++;
            lat = k;
         end
         if (!bus.busy) break;
         busy_n++;
         if (k == poke_k) begin
            bus.start     = 1'b1;
            bus.clear_acc = 1'b1;
            bus.a_in      = 8'hFF;
            bus.b_in      = 8'hFF;
         end else begin
            bus.start     = 1'b0;
            bus.clear_acc = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start     = 1'b0;
      bus.clear_acc = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.accumulate = 1'b0;
      bus.clear_acc  = 1'b0;
      bus.a_in       = 8'h00;
      bus.b_in       = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", bus.product); end
      checks++; if (bus.acc !== 20'h00000) begin errors++; $display("FAIL reset_acc: got %h expected 00000", bus.acc); end
      checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.acc_ovf); end
   endtask

   task automatic test_latency();
      int dc, lat, bn;
      do_op(8'hFF, 8'hFF, 1'b0, 1'b0, -1, dc, lat, bn);
      checks++; if (lat != 9) begin errors++; $display("FAIL lat_done: got %0d expected 9", lat); end
      checks++; if (bn != 10) begin errors++; $display("FAIL lat_busy: got %0d expected 10", bn); end
      checks++; if (dc != 1) begin errors++; $display("FAIL lat_done_cnt: got %0d expected 1", dc); end
      checks++; if (bus.product !== 16'hFE01) begin errors++; $display("FAIL lat_product: got %h expected fe01", bus.product); end
      checks++; if (bus.acc !== 20'h00000) begin errors++; $display("FAIL lat_acc: got %h expected 00000", bus.acc); end
   endtask

   task automatic test_accumulate();
      int dc, lat, bn;
      bus.clear_acc = 1'b1;
      @(posedge clk); #1;
      bus.clear_acc = 1'b0;
      do_op(8'h0D, 8'h0B, 1'b1, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.product !== 16'h008F) begin errors++; $display("FAIL acc1_product: got %h expected 008f", bus.product); end
      checks++; if (bus.acc !== 20'h0008F) begin errors++; $display("FAIL acc1_acc: got %h expected 0008f", bus.acc); end
      do_op(8'h0D, 8'h0B, 1'b1, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.product !== 16'h008F) begin errors++; $display("FAIL acc2_product: got %h expected 008f", bus.product); end
      checks++; if (bus.acc !== 20'h0011E) begin errors++; $display("FAIL acc2_acc: got %h expected 0011e", bus.acc); end
      checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL acc2_ovf: got %b expected 0", bus.acc_ovf); end
   endtask

   task automatic test_busy_ignore();
      int dc, lat, bn;
      int extra;
      do_op(8'h03, 8'h05, 1'b0, 1'b0, 3, dc, lat, bn);
      checks++; if (dc != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d expected 1", dc); end
      checks++; if (bus.product !== 16'h000F) begin errors++; $display("FAIL ign_product: got %h expected 000f", bus.product); end
      checks++; if (bus.acc !== 20'h0011E) begin errors++; $display("FAIL ign_acc: got %h expected 0011e", bus.acc); end
      extra = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.done || bus.busy) extra++;
         @(posedge clk); #1;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL ign_second_op: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_overflow();
      int dc, lat, bn;
      bus.clear_acc = 1'b1;
      @(posedge clk); #1;
      bus.clear_acc = 1'b0;
      for (int n = 0; n < 16; n++) begin
         do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, dc, lat, bn);
      end
      checks++; if (bus.acc !== 20'hFE010) begin errors++; $display("FAIL ovf16_acc: got %h expected fe010", bus.acc); end
      checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL ovf16_ovf: got %b expected 0", bus.acc_ovf); end
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.acc !== 20'h0DE11) begin errors++; $display("FAIL ovf17_acc: got %h expected 0de11", bus.acc); end
      checks++; if (bus.acc_ovf !== 1'b1) begin errors++; $display("FAIL ovf17_ovf: got %b expected 1", bus.acc_ovf); end
      // Overflow stays set across a non-accumulating op.
      do_op(8'h01, 8'h01, 1'b0, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.acc_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.acc_ovf); end
      bus.clear_acc = 1'b1;
      @(posedge clk); #1;
      bus.clear_acc = 1'b0;
      checks++; if (bus.acc !== 20'h00000) begin errors++; $display("FAIL clr_acc: got %h expected 00000", bus.acc); end
      checks++; if (bus.acc_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", bus.acc_ovf); end
   endtask

   task automatic test_mid_reset();
      int dc, lat, bn;
      int stray;
      bus.start      = 1'b1;
      bus.a_in       = 8'hAA;
      bus.b_in       = 8'h55;
      bus.accumulate = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b expected 0", bus.done); end
      checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL mrst_product: got %h expected 0000", bus.product); end
      checks++; if (bus.acc !== 20'h00000) begin errors++; $display("FAIL mrst_acc: got %h expected 00000", bus.acc); end
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.done) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL mrst_no_done: got %0d expected 0", stray); end
      do_op(8'hAA, 8'h55, 1'b0, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.product !== 16'h3872) begin errors++; $display("FAIL mrst_product2: got %h expected 3872", bus.product); end
      checks++; if (dc != 1) begin errors++; $display("FAIL mrst_done_cnt: got %0d expected 1", dc); end
   endtask

   task automatic test_clear_with_start();
      int dc, lat, bn;
      do_op(8'h0D, 8'h0B, 1'b1, 1'b0, -1, dc, lat, bn);
      checks++; if (bus.acc !== 20'h0008F) begin errors++; $display("FAIL cs_pre_acc: got %h expected 0008f", bus.acc); end
      do_op(8'h02, 8'h03, 1'b1, 1'b1, -1, dc, lat, bn);
      checks++; if (bus.acc !== 20'h00006) begin errors++; $display("FAIL cs_acc: got %h expected 00006", bus.acc); end
      checks++; if (bus.product !== 16'h0006) begin errors++; $display("FAIL cs_product: got %h expected 0006", bus.product); end
   endtask

   task automatic test_zero_operand();
      int dc, lat, bn;
      do_op(8'h00, 8'h00, 1'b1, 1'b0, -1, dc, lat, bn);
      checks++; if (bn != 10) begin errors++; $display("FAIL zero_busy: got %0d expected 10", bn); end
      checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h expected 0000", bus.product); end
      checks++; if (bus.acc !== 20'h00006) begin errors++; $display("FAIL zero_acc: got %h expected 00006", bus.acc); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_accumulate();
      test_busy_ignore();
      test_overflow();
      test_mid_reset();
      test_clear_with_start();
      test_zero_operand();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
